dcache_tag_ctrl: RTL and testbench
==================================

// Module: dcache_tag_ctrl
// PURPOSE
//  Sequencer for the dcache tag FIFO. Accepts one CPU lookup at a time and compares its tag
//  against all FIFO entries. On a hit it acks, and on a clean write hit it sets the dirty bit.
//  On a miss it writes back the victim (when FIFO full and victim dirty), refills, then installs
//  the tag. Sits between the CPU load/store port, the tag FIFO and the line-memory engine.
// PARAMETERS
//  DP   4          tag FIFO depth (power of 2, 4..256); AW=$clog2(DP)
//  TW   `TAG_XLEN  tag width
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-high reset
//  cpu_req       in   1    lookup request, sampled only in IDLE
//  cpu_we        in   1    request is a store
//  cpu_tag       in   TW   request tag
//  cpu_busy      out  1    state != IDLE
//  cpu_ack       out  1    one-cycle completion pulse
//  flush_req     in   1    invalidate all tags (no writeback; caller drains dirty lines first)
//  tag_flush     out  1    to FIFO flush
//  tag_wr        out  1    to FIFO: write at tag_wptr
//  tag_uwr       out  1    to FIFO: update at tag_uptr
//  tag_uptr      out  AW   update location
//  tag_wdata     out  TW+2 {valid,dirty,tag} in type_cache_tag_mem_s layout
//  tag_cmp_data  out  TW   compare tag (= latched req tag)
//  tag_hit       in   DP   per-entry hit vector
//  tag_hindex    in   AW   hit index
//  tag_hdirty    in   1    dirty bit of hit entry
//  tag_ctag      in   TW   tag at tag_wptr (victim)
//  tag_cdirty    in   1    dirty bit at tag_wptr
//  tag_full      in   1    FIFO full (victim valid)
//  wb_req/wb_ack out/in 1  victim writeback handshake; wb_tag out TW = latched tag_ctag
//  rf_req/rf_ack out/in 1  refill handshake; rf_tag out TW = latched req tag
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (incl. latched tag, so tag_cmp_data=0). Reset mid-op
//   abandons the op; no ack issued; late wb_ack/rf_ack ignored.
//  Req latch (req_tag, req_we, victim tag) loads only on IDLE acceptance or LOOKUP->WBACK.
//  IDLE: flush_req has priority -> tag_flush=1 this cycle, stay IDLE, cpu_req not accepted.
//   Else cpu_req -> latch tag/we, ->LOOKUP.
//  LOOKUP (1 cycle, combinational outputs):
//   |tag_hit & !req_we -> cpu_ack=1, ->IDLE.
//   |tag_hit & req_we & tag_hdirty -> cpu_ack=1, ->IDLE (already dirty, no write).
//   |tag_hit & req_we & !tag_hdirty -> latch tag_hindex, ->UPDATE.
//   miss & tag_full & tag_cdirty -> latch tag_ctag into wb_tag, ->WBACK.
//   other miss -> REFILL.
//  WBACK: wb_req=1 held until the wb_ack cycle; ->REFILL next cycle.
//  REFILL: rf_req=1 held until the rf_ack cycle; ->FILL.
//  FILL: tag_wr=1, tag_wdata={1,req_we,req_tag}, cpu_ack=1, all for 1 cycle; ->IDLE.
//   FIFO advances tag_wptr and overwrites the victim when full.
//  UPDATE: tag_uwr=1, tag_uptr=latched hindex, tag_wdata={1,1,req_tag}, cpu_ack=1 (1 cycle);
//   ->IDLE.
//  Invariants:
//   - tag_wr, tag_uwr and tag_flush mutually exclusive.
//   - cpu_ack at most 1 cycle per accepted req.
//   - wb_req/rf_req never both high.
//  Latency, req cycle 0: read hit ack cycle 1; clean store hit ack 2; miss (acks same cycle as
//   req) ack 3 (+1 if dirty victim).
//  Multiple tag_hit bits (should not occur) -> FIFO's tag_hindex used as-is.
//  cpu_req while busy is ignored; requester holds until !cpu_busy.
// TESTING
//  1 Empty FIFO, read tag 0x12, rf_ack same cycle as rf_req -> tag_wr c3 with {1,0,0x12},
//    ack c3, no wb_req.
//  2 Re-read 0x12 -> cpu_ack c1, no tag_wr/uwr/rf_req.
//  3 Store 0x12 (clean) -> tag_uwr c2, tag_uptr=0, wdata {1,1,0x12}, ack c2.
//    Repeat store -> ack c1, no uwr.
//  4 Fill DP=4 entries (0x12 dirty first), miss 0x40 -> wb_req wb_tag=0x12; wb_ack after 3 cyc
//    -> rf_req; rf_ack -> tag_wr {1,0,0x40} into slot 0.
//  5 flush_req & cpu_req together in IDLE -> tag_flush 1 cyc, req not taken; next lookup 0x40
//    misses, no wb.
//  6 reset asserted in REFILL -> next cycle IDLE, all outputs 0; later rf_ack -> no tag_wr/ack.

Source files
------------

// File: rtl/dcache_tag_ctrl_if.sv
// Bus between the dcache tag sequencer and its CPU port, tag FIFO and line-memory engine.
// master = the sequencer itself, slave = the surrounding environment.
`ifndef TAG_XLEN
`define TAG_XLEN 20
`endif

interface dcache_tag_ctrl_if #(
  parameter int DP = 4,
  parameter int TW = `TAG_XLEN
);
  localparam int AW = $clog2(DP);

  logic          cpu_req;
  logic          cpu_we;
  logic [TW-1:0] cpu_tag;
  logic          cpu_busy;
  logic          cpu_ack;
  logic          flush_req;
  logic          tag_flush;
  logic          tag_wr;
  logic          tag_uwr;
  logic [AW-1:0] tag_uptr;
  logic [TW+1:0] tag_wdata;
  logic [TW-1:0] tag_cmp_data;
  logic [DP-1:0] tag_hit;
  logic [AW-1:0] tag_hindex;
  logic          tag_hdirty;
  logic [TW-1:0] tag_ctag;
  logic          tag_cdirty;
  logic          tag_full;
  logic          wb_req;
  logic          wb_ack;
  logic [TW-1:0] wb_tag;
  logic          rf_req;
  logic          rf_ack;
  logic [TW-1:0] rf_tag;

  modport master (
    input  cpu_req, cpu_we, cpu_tag, flush_req,
    input  tag_hit, tag_hindex, tag_hdirty, tag_ctag, tag_cdirty, tag_full,
    input  wb_ack, rf_ack,
    output cpu_busy, cpu_ack, tag_flush, tag_wr, tag_uwr, tag_uptr, tag_wdata,
    output tag_cmp_data, wb_req, wb_tag, rf_req, rf_tag
  );

  modport slave (
    output cpu_req, cpu_we, cpu_tag, flush_req,
    output tag_hit, tag_hindex, tag_hdirty, tag_ctag, tag_cdirty, tag_full,
    output wb_ack, rf_ack,
    input  cpu_busy, cpu_ack, tag_flush, tag_wr, tag_uwr, tag_uptr, tag_wdata,
    input  tag_cmp_data, wb_req, wb_tag, rf_req, rf_tag
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Dcache tag FIFO sequencer: one CPU lookup at a time, hit/update, or
// victim writeback + refill + install on a miss.
`ifndef TAG_XLEN
`define TAG_XLEN 20
`endif

module dcache_tag_ctrl #(
  parameter int DP = 4,
  parameter int TW = `TAG_XLEN
) (
  input logic               clk,
  input logic               reset,
  dcache_tag_ctrl_if.master bus
);
  localparam int AW = $clog2(DP);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    REFILL,
    FILL,
    UPDATE
  } state_t;

  state_t        state, nstate;
  logic [TW-1:0] req_tag;
  logic          req_we;
  logic [TW-1:0] vic_tag;
  logic [AW-1:0] upd_idx;
  logic          accept, ld_vic, ld_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_tag <= '0;
      req_we  <= 1'b0;
      vic_tag <= '0;
      upd_idx <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        req_tag <= bus.cpu_tag;
        req_we  <= bus.cpu_we;
      end
      if (ld_vic) vic_tag <= bus.tag_ctag;
      if (ld_idx) upd_idx <= bus.tag_hindex;
    end
  end

  assign bus.cpu_busy     = (state != IDLE);
  assign bus.tag_cmp_data = req_tag;
  assign bus.rf_tag       = req_tag;
  assign bus.wb_tag       = vic_tag;
  assign bus.tag_uptr     = upd_idx;

  // Strobes are suppressed while reset is high so an abandoned op never acks or writes.
  always_comb begin
    nstate        = state;
    accept        = 1'b0;
    ld_vic        = 1'b0;
    ld_idx        = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.tag_flush = 1'b0;
    bus.tag_wr    = 1'b0;
    bus.tag_uwr   = 1'b0;
    bus.tag_wdata = '0;
    bus.wb_req    = 1'b0;
    bus.rf_req    = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (bus.flush_req) begin
            bus.tag_flush = 1'b1;
          end else if (bus.cpu_req) begin
            accept = 1'b1;
            nstate = LOOKUP;
          end
        end
        LOOKUP: begin
          if (|bus.tag_hit) begin
            if (!req_we || bus.tag_hdirty) begin
              bus.cpu_ack = 1'b1;
              nstate      = IDLE;
            end else begin
              ld_idx = 1'b1;
              nstate = UPDATE;
            end
          end else if (bus.tag_full && bus.tag_cdirty) begin
            ld_vic = 1'b1;
            nstate = WBACK;
          end else begin
            nstate = REFILL;
          end
        end
        WBACK: begin
          bus.wb_req = 1'b1;
          if (bus.wb_ack) nstate = REFILL;
        end
        REFILL: begin
          bus.rf_req = 1'b1;
          if (bus.rf_ack) nstate = FILL;
        end
        FILL: begin
          bus.tag_wr    = 1'b1;
          bus.tag_wdata = {1'b1, req_we, req_tag};
          bus.cpu_ack   = 1'b1;
          nstate        = IDLE;
        end
        UPDATE: begin
          bus.tag_uwr   = 1'b1;
          bus.tag_wdata = {2'b11, req_tag};
          bus.cpu_ack   = 1'b1;
          nstate        = IDLE;
        end
        default: nstate = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Self-checking bench for dcache_tag_ctrl: directed scenarios then random lookups
// against a transaction-level cache model.
module tb_dcache_tag_ctrl;
  localparam int DP = 4;
  localparam int TW = 20;
  localparam int AW = $clog2(DP);

  logic clk = 1'b0;
  logic reset;
  logic fifo_rst;
  always #5 clk = ~clk;

  dcache_tag_ctrl_if #(.DP(DP), .TW(TW)) bus ();
  dcache_tag_ctrl #(.DP(DP), .TW(TW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Environment tag FIFO: reacts to the DUT's write/update/flush strobes.
  logic          fv [DP];
  logic          fd [DP];
  logic [TW-1:0] ft [DP];
  logic [AW-1:0] fwp;

  always @(posedge clk) begin
    if (fifo_rst || bus.tag_flush) begin
      for (int i = 0; i < DP; i++) fv[i] <= 1'b0;
      fwp <= '0;
    end else if (bus.tag_wr) begin
      fv[fwp] <= bus.tag_wdata[TW+1];
      fd[fwp] <= bus.tag_wdata[TW];
      ft[fwp] <= bus.tag_wdata[TW-1:0];
      fwp     <= fwp + 1'b1;
    end else if (bus.tag_uwr) begin
      fv[bus.tag_uptr] <= bus.tag_wdata[TW+1];
      fd[bus.tag_uptr] <= bus.tag_wdata[TW];
      ft[bus.tag_uptr] <= bus.tag_wdata[TW-1:0];
    end
  end

  always_comb begin
    bus.tag_hit    = '0;
    bus.tag_hindex = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (fv[i] === 1'b1 && ft[i] === bus.tag_cmp_data) begin
        bus.tag_hit[i] = 1'b1;
        bus.tag_hindex = AW'(i);
      end
    end
    bus.tag_hdirty = fd[bus.tag_hindex];
    bus.tag_ctag   = ft[fwp];
    bus.tag_cdirty = fd[fwp];
    bus.tag_full   = fv[fwp];
  end

  // Expected cache contents, updated from predictions only.
  logic          ev [DP];
  logic          ed [DP];
  logic [TW-1:0] et [DP];
  int            ewp;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < DP; i++) ev[i] = 1'b0;
    ewp = 0;
  endtask

  task automatic do_req(input logic [TW-1:0] t, input logic we, input int wbd, input int rfd);
    int hi = -1;
    int exp_ack;
    logic exp_wb = 1'b0, exp_wr = 1'b0, exp_uwr = 1'b0, exp_rf = 1'b0;
    logic [TW-1:0] exp_vic = '0;
    int ack_cyc = -1, acks = 0, wrs = 0, uwrs = 0, wbc = 0, rfc = 0, both = 0;
    logic [TW+1:0] wr_data = '0, uwr_data = '0;
    logic [AW-1:0] uptr_obs = '0;
    logic [TW-1:0] wb_tag_obs = '0, rf_tag_obs = '0;

    for (int i = 0; i < DP; i++) if (ev[i] && et[i] == t) hi = i;
    if (hi >= 0) begin
      if (!we || ed[hi]) exp_ack = 1;
      else begin
        exp_ack = 2;
        exp_uwr = 1'b1;
      end
    end else begin
      exp_wb  = ev[ewp] && ed[ewp];
      exp_vic = et[ewp];
      exp_rf  = 1'b1;
      exp_wr  = 1'b1;
      exp_ack = exp_wb ? 4 + wbd + rfd : 3 + rfd;
    end

    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we  = we;
    bus.cpu_tag = t;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
      bus.wb_ack  = 1'b0;
      bus.rf_ack  = 1'b0;
      @(negedge clk);
      bus.wb_ack = bus.wb_req && (wbc == wbd);
      bus.rf_ack = bus.rf_req && (rfc == rfd);
      #1;
      if (bus.cpu_ack) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = cyc;
      end
      if (bus.tag_wr) begin
        wrs++;
        wr_data = bus.tag_wdata;
      end
      if (bus.tag_uwr) begin
        uwrs++;
        uwr_data = bus.tag_wdata;
        uptr_obs = bus.tag_uptr;
      end
      if (bus.wb_req) begin
        if (wbc == 0) wb_tag_obs = bus.wb_tag;
        wbc++;
      end
      if (bus.rf_req) begin
        if (rfc == 0) rf_tag_obs = bus.rf_tag;
        rfc++;
      end
      if (bus.wb_req && bus.rf_req) both++;
      if (ack_cyc >= 0 && cyc > ack_cyc) break;
    end
    bus.wb_ack = 1'b0;
    bus.rf_ack = 1'b0;

    check("ack_cycle", 64'(ack_cyc), 64'(exp_ack));
    check("ack_count", 64'(acks), 64'd1);
    check("busy_after", {63'd0, bus.cpu_busy}, 64'd0);
    check("wr_count", 64'(wrs), {63'd0, exp_wr});
    check("uwr_count", 64'(uwrs), {63'd0, exp_uwr});
    check("wb_seen", {63'd0, wbc > 0}, {63'd0, exp_wb});
    check("rf_seen", {63'd0, rfc > 0}, {63'd0, exp_rf});
    check("wb_rf_overlap", 64'(both), 64'd0);
    if (exp_wr) check("wr_data", 64'(wr_data), 64'({1'b1, we, t}));
    if (exp_uwr) begin
      check("uwr_data", 64'(uwr_data), 64'({2'b11, t}));
      check("uwr_ptr", 64'(uptr_obs), 64'(hi));
    end
    if (exp_wb) check("wb_tag", 64'(wb_tag_obs), 64'(exp_vic));
    if (exp_rf) check("rf_tag", 64'(rf_tag_obs), 64'(t));

    if (exp_uwr) ed[hi] = 1'b1;
    if (exp_wr) begin
      ev[ewp] = 1'b1;
      ed[ewp] = we;
      et[ewp] = t;
      ewp     = (ewp + 1) % DP;
    end
  endtask

  task automatic do_flush(input logic with_req, input logic [TW-1:0] t);
    @(negedge clk);
    bus.flush_req = 1'b1;
    bus.cpu_req   = with_req;
    bus.cpu_we    = 1'b0;
    bus.cpu_tag   = t;
    #1;
    check("flush_pulse", {63'd0, bus.tag_flush}, 64'd1);
    check("flush_no_wr", {62'd0, bus.tag_wr, bus.tag_uwr}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    bus.cpu_req   = 1'b0;
    @(negedge clk);
    check("flush_not_taken", {63'd0, bus.cpu_busy}, 64'd0);
    check("flush_one_cycle", {63'd0, bus.tag_flush}, 64'd0);
    model_flush();
  endtask

  initial begin
    int seen, bad;
    reset         = 1'b1;
    fifo_rst      = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_tag   = '0;
    bus.flush_req = 1'b0;
    bus.wb_ack    = 1'b0;
    bus.rf_ack    = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    fifo_rst = 1'b0;
    #1;
    check("rst_busy", {63'd0, bus.cpu_busy}, 64'd0);
    check("rst_cmp_data", 64'(bus.tag_cmp_data), 64'd0);
    check("rst_strobes", {59'd0, bus.cpu_ack, bus.tag_wr, bus.tag_uwr, bus.wb_req, bus.rf_req}, 64'd0);
    check("rst_wb_tag", 64'(bus.wb_tag), 64'd0);

    do_req(20'h12, 1'b0, 0, 0);   // cold miss, fill c3
    do_req(20'h12, 1'b0, 0, 0);   // read hit c1
    do_req(20'h12, 1'b1, 0, 0);   // clean store hit -> update c2
    do_req(20'h12, 1'b1, 0, 0);   // dirty store hit c1
    do_req(20'h20, 1'b0, 0, 0);
    do_req(20'h21, 1'b0, 0, 1);
    do_req(20'h22, 1'b0, 0, 0);
    do_req(20'h40, 1'b0, 3, 0);   // dirty victim 0x12 written back
    do_flush(1'b1, 20'h40);
    do_req(20'h40, 1'b0, 0, 0);   // misses after flush, no wb

    // Reset while waiting in REFILL.
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    bus.cpu_tag = 20'h55;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.rf_req) seen = 1;
    end
    check("mid_reset_reached_refill", 64'(seen), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_busy", {63'd0, bus.cpu_busy}, 64'd0);
    check("mid_reset_rf_req", {63'd0, bus.rf_req}, 64'd0);
    check("mid_reset_cmp_data", 64'(bus.tag_cmp_data), 64'd0);
    check("mid_reset_rf_tag", 64'(bus.rf_tag), 64'd0);
    bus.rf_ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.tag_wr || bus.cpu_ack || bus.tag_uwr) bad++;
      @(posedge clk);
      #1;
      bus.rf_ack = 1'b0;
      @(negedge clk);
    end
    check("late_rf_ack_ignored", 64'(bad), 64'd0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(15) == 0) do_flush(1'($urandom_range(1)), 20'h10);
      else do_req(20'h10 + TW'($urandom_range(7)), 1'($urandom_range(1)),
                  int'($urandom_range(3)), int'($urandom_range(3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
